// File: rtl/input_cond_pkg.sv
// Shared constants, debounce state type and counter-width helper for the input conditioner.
package input_cond_pkg;

  localparam int CLK_HZ    = 50_000_000;
  localparam int DEB_10MS  = 500_000;
  localparam int RPT_500MS = 25_000_000;
  localparam int RPT_100MS = 5_000_000;

  typedef enum logic {
    DEB_IDLE,
    DEB_COUNT
  } deb_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One channel: synchroniser chain, debounce FSM, edge pulses and optional auto-repeat.
// Auto-repeat is built only when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter bit RST_BIT         = 1'b0,
  parameter int REPEAT_DELAY    = RPT_500MS,
  parameter int REPEAT_PERIOD   = RPT_100MS
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  deb_state_t             st, st_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   q_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync <= {SYNC_STAGES{RST_BIT}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st   <= DEB_IDLE;
      cnt  <= '0;
      q    <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      q    <= q_nxt;
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end

  // The counter only advances while s disagrees with q and never passes TERM.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    q_nxt   = q;
    case (st)
      DEB_IDLE: begin
        if (s != q) begin
          if (cnt == TERM) begin
            q_nxt = s;
          end else begin
            cnt_nxt = cnt + 1'b1;
            st_nxt  = DEB_COUNT;
          end
        end
      end
      DEB_COUNT: begin
        if (s == q) begin
          st_nxt = DEB_IDLE;
        end else if (cnt == TERM) begin
          q_nxt  = s;
          st_nxt = DEB_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: st_nxt = DEB_IDLE;
    endcase
  end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rterm;
  logic          first;
  logic          pressed_now;
  logic          pressed_nxt;

  assign pressed_now = q ^ RST_BIT;
  assign pressed_nxt = q_nxt ^ RST_BIT;
  assign rterm       = first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);

  // Both the press edge and any release edge restart the sequence, so no pulse lands on a release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rcnt  <= '0;
      first <= 1'b1;
      rpt   <= 1'b0;
    end else if (!pressed_nxt || !pressed_now) begin
      rcnt  <= '0;
      first <= 1'b1;
      rpt   <= 1'b0;
    end else if (rcnt == rterm) begin
      rcnt  <= '0;
      first <= 1'b0;
      rpt   <= 1'b1;
    end else begin
      rcnt  <= rcnt + 1'b1;
      rpt   <= 1'b0;
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchroniser/debouncer with rise/fall pulses and a combined change flag.
// Optional auto-repeat pulses on rpt when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEB_10MS,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0,
  parameter int               REPEAT_DELAY    = RPT_500MS,
  parameter int               REPEAT_PERIOD   = RPT_100MS
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [WIDTH-1:0] rpt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_BIT         (RESET_VAL[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .d       (d[i]),
      .q       (q[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .rpt     (rpt[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed-vector bench for input_conditioner with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

  logic       Clk;
  logic       Reset_n;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic [3:0] rpt;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  input_conditioner #(
    .WIDTH           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VAL       (4'h0),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (d),
    .q       (q),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .rpt     (rpt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    d       = 4'hF;
    tick(3);
    chk("rst_q", q, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    chk("rst_changed", changed, 1'b0);
    chk("rst_rpt", rpt, 4'h0);

    d       = 4'h0;
    Reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (changed || (rpt != 4'h0) || (rise != 4'h0) || (fall != 4'h0)) pulses++;
    end
    chk("idle_no_pulse", pulses, 0);

    // single-channel rise and fall latency
    d = 4'b0001;
    tick(5);
    chk("rise_early_q", q, 4'h0);
    tick(1);
    chk("rise_q", q, 4'b0001);
    chk("rise_pulse", rise, 4'b0001);
    chk("rise_nofall", fall, 4'h0);
    chk("rise_changed", changed, 1'b1);
    tick(1);
    chk("rise_one_cycle", rise, 4'h0);
    chk("rise_changed_off", changed, 1'b0);
    d = 4'b0000;
    tick(5);
    chk("fall_early_q", q, 4'b0001);
    tick(1);
    chk("fall_q", q, 4'h0);
    chk("fall_pulse", fall, 4'b0001);
    chk("fall_norise", rise, 4'h0);
    tick(1);
    chk("fall_one_cycle", fall, 4'h0);

    // glitch of 3 cycles is rejected, 4 cycles accepted
    d = 4'b0010;
    tick(3);
    d      = 4'b0000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (changed) pulses++;
    end
    chk("glitch3_pulses", pulses, 0);
    chk("glitch3_q", q, 4'h0);
    d = 4'b0010;
    tick(4);
    d = 4'b0000;
    tick(2);
    chk("hold4_q", q, 4'b0010);
    chk("hold4_rise", rise, 4'b0010);
    tick(6);
    chk("hold4_released", q, 4'h0);

    // simultaneous opposite transitions on two channels
    d = 4'b1000;
    tick(6);
    chk("preload_q3", q, 4'b1000);
    tick(1);
    d = 4'b0100;
    tick(5);
    chk("simul_early_changed", changed, 1'b0);
    tick(1);
    chk("simul_rise", rise, 4'b0100);
    chk("simul_fall", fall, 4'b1000);
    chk("simul_changed", changed, 1'b1);
    chk("simul_q", q, 4'b0100);
    tick(1);
    chk("simul_changed_off", changed, 1'b0);

    // reset in the middle of a count
    d = 4'b0101;
    tick(5);
    Reset_n = 1'b0;
    #1;
    chk("midrst_q", q, 4'h0);
    chk("midrst_rise", rise, 4'h0);
    tick(2);
    Reset_n = 1'b1;
    tick(5);
    chk("postrst_early_q", q, 4'h0);
    tick(1);
    chk("postrst_q", q, 4'b0101);
    chk("postrst_rise", rise, 4'b0101);
    tick(1);
    chk("postrst_rise_off", rise, 4'h0);

    // auto-repeat timing and release suppression
    d = 4'b0000;
    tick(8);
    chk("rpt_setup_q", q, 4'h0);
    d = 4'b0001;
    tick(6);
    chk("rpt_press_rise", rise, 4'b0001);
    chk("rpt_press_no_rpt", rpt, 4'h0);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      if (k == 14) d = 4'b0000;
      chk($sformatf("rpt_k%0d", k), rpt,
          {3'b000, RPT_EN & ((k == 8) || (k == 11) || (k == 14) || (k == 17))});
      if (k == 20) chk("rpt_release_fall", fall, 4'b0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
